// File: rtl/vyapaar_pkg.sv
// Shared fixed-point constants, element type and bank selector for the
// matrix assembly path.
package vyapaar_pkg;

    localparam int FRAC_BITS = 10;
    localparam logic signed [15:0] ONE = 16'sd1024;

    typedef logic signed [15:0] elem_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// One N x N register bank: single write port addressed by row-major index,
// synchronous clear, and the whole bank exposed as a packed matrix.
module matrix_bank #(
    parameter int N_STOCKS = 2,
    parameter int WIDTH    = 16,
    parameter int IDXW     = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       we,
    input  logic [IDXW-1:0]                            idx,
    input  logic [WIDTH-1:0]                           data,
    input  logic                                       clr,
    output logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat
);

    // Flat row-major storage; bit layout matches mat[r][c] at r*N+c.
    logic [N_STOCKS*N_STOCKS-1:0][WIDTH-1:0] mem;

    // Element storage: zero on reset or clear, otherwise write one element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else if (we) begin
            mem[idx] <= data;
        end
    end

    assign mat = mem;

endmodule

// File: rtl/matrix_builder.sv
// Double-buffered row-major stream to packed N x N matrix assembler.
// Optional feature macro: ROWSUM_EN adds per-row sums of the read bank,
// accumulated during fill.
module matrix_builder
    import vyapaar_pkg::*;
#(
    parameter int N_STOCKS = 2,
    parameter int WIDTH    = 16
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic signed [WIDTH-1:0]                           in_data,
    input  logic                                              in_valid,
    input  logic                                              in_last,
    output logic                                              in_ready,
    output logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix,
    output logic                                              matrix_valid,
    input  logic                                              matrix_ack,
    output logic                                              frame_err,
    output logic [15:0]                                       frame_count
`ifdef ROWSUM_EN
    ,
    output logic signed [N_STOCKS-1:0][WIDTH+((N_STOCKS > 1) ? $clog2(N_STOCKS) : 1)-1:0] row_sum
`endif
);

    localparam int NN   = N_STOCKS * N_STOCKS;
    localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;

    bank_t             wr_bank;
    bank_t             rd_bank;
    logic [1:0]        bank_full;
    logic [IDXW-1:0]   elem_idx;

    logic accept;
    logic last_idx;
    logic complete;
    logic discard;
    logic ack_take;

    logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat0;
    logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat1;

    assign in_ready     = !bank_full[wr_bank];
    assign matrix_valid = bank_full[rd_bank];
    assign accept       = in_valid && in_ready;
    assign last_idx     = (elem_idx == IDXW'(NN - 1));
    assign complete     = accept && last_idx && in_last;
    // Frame error: in_last disagrees with the index position.
    assign discard      = accept && (last_idx != in_last);
    assign ack_take     = matrix_valid && matrix_ack;

    assign matrix = (rd_bank == BANK1) ? mat1 : mat0;

    matrix_bank #(
        .N_STOCKS (N_STOCKS),
        .WIDTH    (WIDTH),
        .IDXW     (IDXW)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && (wr_bank == BANK0)),
        .idx   (elem_idx),
        .data  (in_data),
        .clr   (discard && (wr_bank == BANK0)),
        .mat   (mat0)
    );

    matrix_bank #(
        .N_STOCKS (N_STOCKS),
        .WIDTH    (WIDTH),
        .IDXW     (IDXW)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && (wr_bank == BANK1)),
        .idx   (elem_idx),
        .data  (in_data),
        .clr   (discard && (wr_bank == BANK1)),
        .mat   (mat1)
    );

    // Fill/hold control: element index, bank ownership, full flags, error and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= BANK0;
            rd_bank     <= BANK0;
            bank_full   <= '0;
            elem_idx    <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_err <= discard;
            if (accept) begin
                if (complete) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= other_bank(wr_bank);
                    elem_idx           <= '0;
                    frame_count        <= frame_count + 16'd1;
                end else if (discard) begin
                    elem_idx <= '0;
                end else begin
                    elem_idx <= elem_idx + IDXW'(1);
                end
            end
            // Completion and ack always hit different banks, so both flag writes are safe.
            if (ack_take) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= other_bank(rd_bank);
            end
        end
    end

`ifdef ROWSUM_EN
    localparam int RW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam int SW = WIDTH + RW;

    logic [1:0][N_STOCKS-1:0][SW-1:0] acc;
    logic [RW-1:0]                    wr_row;

    assign wr_row  = RW'(32'(elem_idx) / N_STOCKS);
    assign row_sum = acc[rd_bank];

    // Per-bank row accumulators; the first element of a frame restarts the bank's sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            if (discard) begin
                acc[wr_bank] <= '0;
            end else if (elem_idx == '0) begin
                acc[wr_bank]    <= '0;
                acc[wr_bank][0] <= SW'(in_data);
            end else begin
                acc[wr_bank][wr_row] <= acc[wr_bank][wr_row] + SW'(in_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_builder.sv
// Self-checking bench for matrix_builder (N_STOCKS=2, WIDTH=16) against a
// frame-queue reference model. Row-sum checks build when ROWSUM_EN is defined.
module tb_matrix_builder;
    import vyapaar_pkg::*;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int W  = 16;
    localparam int SW = W + 1;

    typedef logic [W-1:0] frame_t [NN];

    logic                               clk;
    logic                               rst_n;
    logic signed [W-1:0]                in_data;
    logic                               in_valid;
    logic                               in_last;
    logic                               in_ready;
    logic signed [N-1:0][N-1:0][W-1:0]  matrix;
    logic                               matrix_valid;
    logic                               matrix_ack;
    logic                               frame_err;
    logic [15:0]                        frame_count;
`ifdef ROWSUM_EN
    logic signed [N-1:0][SW-1:0]        row_sum;
`endif

    matrix_builder #(
        .N_STOCKS (N),
        .WIDTH    (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .matrix       (matrix),
        .matrix_valid (matrix_valid),
        .matrix_ack   (matrix_ack),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
`ifdef ROWSUM_EN
        ,
        .row_sum      (row_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: completed frames waiting for the consumer, plus the partial frame.
    frame_t       held[$];
    logic [W-1:0] part[$];
    logic [15:0]  exp_cnt;
    logic         exp_err;
    logic         exp_ready;
    logic         ready_seen;
    logic [N-1:0][N-1:0][W-1:0] exp_mat;

    task automatic model_reset();
        held.delete();
        part.delete();
        exp_cnt = '0;
        exp_err = 1'b0;
    endtask

    function automatic logic [N-1:0][N-1:0][W-1:0] frame_to_mat(input frame_t f);
        logic [N-1:0][N-1:0][W-1:0] m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = f[r*N + c];
        return m;
    endfunction

    // Drive one cycle from a falling edge, advance the model at the rising edge,
    // return at the next falling edge with outputs settled.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic a);
        logic   acc;
        frame_t f;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        matrix_ack = a;
        #1;
        exp_ready  = (held.size() < 2);
        ready_seen = in_ready;
        acc        = v && exp_ready;
        @(posedge clk);
        if (a && held.size() > 0) void'(held.pop_front());
        exp_err = 1'b0;
        if (acc) begin
            part.push_back(d);
            if (part.size() == NN && l) begin
                for (int i = 0; i < NN; i++) f[i] = part[i];
                held.push_back(f);
                exp_cnt = exp_cnt + 16'd1;
                part.delete();
            end else if (part.size() == NN || l) begin
                exp_err = 1'b1;
                part.delete();
            end
        end
        exp_mat = (held.size() > 0) ? frame_to_mat(held[0]) : '0;
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        matrix_ack = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < NN; i++) cycle(1'b1, f[i], (i == NN - 1), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && held.size() > 0; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; matrix_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (matrix_valid !== 1'b0 || in_ready !== 1'b1 || frame_err !== 1'b0 ||
            matrix !== '0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b err=%b matrix=%h count=%0d required 0 1 0 0 0",
                     matrix_valid, in_ready, frame_err, matrix, frame_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        frame_t f;
        for (int i = 0; i < NN; i++) f[i] = ONE;
        for (int i = 0; i < NN - 1; i++) cycle(1'b1, f[i], 1'b0, 1'b0);
        checks++;
        if (matrix_valid !== 1'b0) begin
            errors++;
            $display("FAIL ones_early_valid: got %b required 0", matrix_valid);
        end
        cycle(1'b1, f[NN-1], 1'b1, 1'b0);
        checks++;
        if (matrix_valid !== 1'b1 || matrix !== frame_to_mat(f) || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL ones_frame: valid=%b matrix=%h count=%0d required 1 %h 1",
                     matrix_valid, matrix, frame_count, frame_to_mat(f));
        end
        drain();
    endtask

    task automatic test_identity_then_zero();
        frame_t id;
        frame_t z;
        id[0] = ONE; id[1] = '0; id[2] = '0; id[3] = ONE;
        for (int i = 0; i < NN; i++) z[i] = '0;
        send_frame(id);
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (matrix_valid !== 1'b1 || matrix !== exp_mat || exp_mat !== frame_to_mat(id)) begin
            errors++;
            $display("FAIL identity_hold: valid=%b matrix=%h required 1 %h",
                     matrix_valid, matrix, frame_to_mat(id));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (matrix_valid !== 1'b0) begin
            errors++;
            $display("FAIL identity_ack: valid=%b required 0", matrix_valid);
        end
        send_frame(z);
        checks++;
        if (matrix_valid !== 1'b1 || matrix !== '0 || frame_count !== exp_cnt) begin
            errors++;
            $display("FAIL zero_frame: valid=%b matrix=%h count=%0d required 1 0 %0d",
                     matrix_valid, matrix, frame_count, exp_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2, f3;
        for (int i = 0; i < NN; i++) begin
            f1[i] = W'($urandom); f2[i] = W'($urandom); f3[i] = W'($urandom);
        end
        send_frame(f1);
        send_frame(f2);
        checks++;
        if (in_ready !== 1'b0 || matrix !== frame_to_mat(f1)) begin
            errors++;
            $display("FAIL b2b_full: ready=%b matrix=%h required 0 %h", in_ready, matrix, frame_to_mat(f1));
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, f3[0], 1'b0, 1'b0);
        checks++;
        if (ready_seen !== 1'b0 || matrix !== frame_to_mat(f1) || matrix_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall: ready=%b valid=%b matrix=%h required 0 1 %h",
                     ready_seen, matrix_valid, matrix, frame_to_mat(f1));
        end
        cycle(1'b1, f3[0], 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || matrix !== frame_to_mat(f2) || matrix_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after_ack: ready=%b valid=%b matrix=%h required 1 1 %h",
                     in_ready, matrix_valid, matrix, frame_to_mat(f2));
        end
        send_frame(f3);
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (matrix !== frame_to_mat(f3) || frame_count !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_third: matrix=%h count=%0d required %h %0d",
                     matrix, frame_count, frame_to_mat(f3), exp_cnt);
        end
        drain();
    endtask

    task automatic test_frame_err();
        frame_t f;
        for (int i = 0; i < NN; i++) f[i] = W'($urandom);
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || matrix_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_early_last: err=%b valid=%b required 1 0", frame_err, matrix_valid);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: err=%b required 0", frame_err);
        end
        // Full-length frame with no in_last is also an error.
        for (int i = 0; i < NN; i++) cycle(1'b1, 16'h3333, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || matrix_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_missing_last: err=%b valid=%b required 1 0", frame_err, matrix_valid);
        end
        send_frame(f);
        checks++;
        if (matrix_valid !== 1'b1 || matrix !== frame_to_mat(f) || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL err_recover: valid=%b err=%b matrix=%h required 1 0 %h",
                     matrix_valid, frame_err, matrix, frame_to_mat(f));
        end
        drain();
    endtask

    task automatic test_random();
        logic l;
        logic a;
        for (int n = 0; n < 400; n++) begin
            if (part.size() == NN - 1) l = ($urandom_range(0, 9) != 0);
            else                       l = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, W'($urandom), l, a);
            checks++;
            if (ready_seen !== exp_ready || matrix_valid !== (held.size() > 0) ||
                frame_err !== exp_err || frame_count !== exp_cnt ||
                (held.size() > 0 && matrix !== exp_mat)) begin
                errors++;
                $display("FAIL random[%0d]: ready=%b valid=%b err=%b count=%0d matrix=%h required %b %b %b %0d %h",
                         n, ready_seen, matrix_valid, frame_err, frame_count, matrix,
                         exp_ready, (held.size() > 0), exp_err, exp_cnt, exp_mat);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        frame_t f;
        for (int i = 0; i < NN; i++) f[i] = W'($urandom);
        send_frame(f);
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (matrix_valid !== 1'b0 || in_ready !== 1'b1 || matrix !== '0 ||
            frame_count !== 16'd0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: valid=%b ready=%b matrix=%h count=%0d err=%b required 0 1 0 0 0",
                     matrix_valid, in_ready, matrix, frame_count, frame_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 16'h7777, 1'b0, 1'b0);
        cycle(1'b1, 16'h7777, 1'b0, 1'b0);
        checks++;
        if (matrix_valid !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_after: valid=%b count=%0d required 0 0", matrix_valid, frame_count);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(f);
        checks++;
        if (matrix_valid !== 1'b1 || matrix !== frame_to_mat(f) || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_mid_frame: valid=%b matrix=%h count=%0d required 1 %h 1",
                     matrix_valid, matrix, frame_count, frame_to_mat(f));
        end
        drain();
    endtask

`ifdef ROWSUM_EN
    task automatic test_rowsum();
        frame_t id;
        frame_t neg;
        int     s;
        id[0] = ONE; id[1] = '0; id[2] = '0; id[3] = ONE;
        neg[0] = ONE; neg[1] = '0; neg[2] = -ONE; neg[3] = -ONE;
        send_frame(id);
        send_frame(neg);
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N; r++) begin
                s = 0;
                for (int c = 0; c < N; c++) s += int'(signed'(held[0][r*N + c]));
                checks++;
                if (row_sum[r] !== SW'(s)) begin
                    errors++;
                    $display("FAIL rowsum[%0d][%0d]: got %0d required %0d", k, r, row_sum[r], s);
                end
            end
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_all_ones();
        test_identity_then_zero();
        test_back_to_back();
        test_frame_err();
        test_random();
        test_reset_mid();
`ifdef ROWSUM_EN
        test_rowsum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
